// File: rtl/pulse_burst_pkg.sv
// Shared types and defaults for the fast-domain burst sequencer.
// Optional pulse queue is enabled by defining PULSE_BURST_QUEUE_EN.
package pulse_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int LEN_W_DEFAULT  = 8;
    localparam int PEND_W_DEFAULT = 2;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter holding queued burst requests.
// Used by pulse_burst_seq only when PULSE_BURST_QUEUE_EN is defined.
module sat_updown_cnt
    import pulse_burst_pkg::*;
#(
    parameter int W = PEND_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_CNT  = {W{1'b1}};
    localparam logic [W-1:0] ZERO_CNT = {W{1'b0}};
    localparam logic [W-1:0] ONE_CNT  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_s;

    // Next count; simultaneous inc and dec cancel, so that case never overflows.
    always_comb begin
        cnt_s = cnt_r;
        ovf   = 1'b0;
        if (clr) begin
            cnt_s = ZERO_CNT;
        end else if (inc && !dec) begin
            if (cnt_r == MAX_CNT) begin
                ovf = 1'b1;
            end else begin
                cnt_s = cnt_r + ONE_CNT;
            end
        end else if (dec && !inc) begin
            if (cnt_r != ZERO_CNT) begin
                cnt_s = cnt_r - ONE_CNT;
            end else begin
                cnt_s = cnt_r;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO_CNT;
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pulse_burst_seq.sv
// Burst sequencer: each accepted pulse yields cfg_len cycles of en_o, then one DONE cycle.
// Define PULSE_BURST_QUEUE_EN to queue pulses arriving mid-burst instead of dropping them.
module pulse_burst_seq
    import pulse_burst_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEFAULT,
    parameter int PEND_W = PEND_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              drop_clr,
    output logic              en_o,
    output logic              first_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              drop_o
);

    localparam logic [LEN_W-1:0] ZERO_LEN = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] cnt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_s;
    logic             en_r;
    logic             first_r;
    logic             last_r;
    logic             busy_r;
    logic             done_r;
    logic             drop_r;
    logic             drop_s;
    logic             drop_set_s;

`ifdef PULSE_BURST_QUEUE_EN
    logic             pend_inc_s;
    logic             pend_dec_s;
    logic             pend_clr_s;
    logic             pend_ovf_s;
    logic             pend_nz_s;

    sat_updown_cnt #(
        .W   (PEND_W)
    ) u_pend_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pend_clr_s),
        .inc (pend_inc_s),
        .dec (pend_dec_s),
        .cnt (pend_o),
        .ovf (pend_ovf_s)
    );

    assign pend_nz_s  = (pend_o != {PEND_W{1'b0}});
    assign drop_set_s = pend_ovf_s;
`else
    assign pend_o     = {PEND_W{1'b0}};
    assign drop_set_s = pulse && (state_r != IDLE);
`endif

    // Next-state, cycle counter and queue control.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        len_s   = len_r;
`ifdef PULSE_BURST_QUEUE_EN
        pend_inc_s = 1'b0;
        pend_dec_s = 1'b0;
        pend_clr_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (pulse && (cfg_len != ZERO_LEN)) begin
                    state_s = BURST;
                    cnt_s   = ONE_LEN;
                    len_s   = cfg_len;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (cnt_r == len_r) begin
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + ONE_LEN;
                end
`ifdef PULSE_BURST_QUEUE_EN
                pend_inc_s = pulse;
`endif
            end
            DONE: begin
`ifdef PULSE_BURST_QUEUE_EN
                // A zero length cannot serve queued requests, so they are discarded quietly.
                if (cfg_len == ZERO_LEN) begin
                    state_s    = IDLE;
                    pend_clr_s = 1'b1;
                end else if (pend_nz_s || pulse) begin
                    state_s    = BURST;
                    cnt_s      = ONE_LEN;
                    len_s      = cfg_len;
                    pend_inc_s = pulse;
                    pend_dec_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
`else
                state_s = IDLE;
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sticky drop flag; a new drop outranks a clear in the same cycle.
    always_comb begin
        if (drop_set_s) begin
            drop_s = 1'b1;
        end else if (drop_clr) begin
            drop_s = 1'b0;
        end else begin
            drop_s = drop_r;
        end
    end

    // State and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= ZERO_LEN;
            len_r   <= ZERO_LEN;
            en_r    <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            len_r   <= len_s;
            en_r    <= (state_s == BURST);
            first_r <= (state_s == BURST) && (cnt_s == ONE_LEN);
            last_r  <= (state_s == BURST) && (cnt_s == len_s);
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            drop_r  <= drop_s;
        end
    end

    assign en_o    = en_r;
    assign first_o = first_r;
    assign last_o  = last_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign drop_o  = drop_r;

endmodule

// File: tb/tb_pulse_burst_seq.sv
// Directed self-checking bench for pulse_burst_seq; queue tests run when PULSE_BURST_QUEUE_EN is defined.
// Flag vectors are {en, first, last, busy, done, drop}.
module tb_pulse_burst_seq;

    localparam int LEN_W  = 8;
    localparam int PEND_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pulse;
    logic [LEN_W-1:0]  cfg_len;
    logic              drop_clr;
    logic              en_o;
    logic              first_o;
    logic              last_o;
    logic              busy_o;
    logic              done_o;
    logic [PEND_W-1:0] pend_o;
    logic              drop_o;

    int checks = 0;
    int errors = 0;

    pulse_burst_seq #(
        .LEN_W    (LEN_W),
        .PEND_W   (PEND_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse    (pulse),
        .cfg_len  (cfg_len),
        .drop_clr (drop_clr),
        .en_o     (en_o),
        .first_o  (first_o),
        .last_o   (last_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .pend_o   (pend_o),
        .drop_o   (drop_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp_f, input logic [PEND_W-1:0] exp_p);
        logic [5:0] obs_f;
        obs_f = {en_o, first_o, last_o, busy_o, done_o, drop_o};
        checks++;
        assert (obs_f === exp_f) else begin
            errors++;
            $error("FAIL %s flags: observed %b expected %b", tag, obs_f, exp_f);
        end
        checks++;
        assert (pend_o === exp_p) else begin
            errors++;
            $error("FAIL %s pend: observed %0d expected %0d", tag, pend_o, exp_p);
        end
    endtask

    initial begin
        rst      = 1'b1;
        pulse    = 1'b0;
        drop_clr = 1'b0;
        cfg_len  = 8'd0;
        tick();
        tick();
        chk("reset", 6'b000000, 2'd0);
        rst = 1'b0;

        // length 4; cfg_len change mid-burst must not shorten it
        cfg_len = 8'd4; pulse = 1'b1;
        tick(); pulse = 1'b0; cfg_len = 8'd2;
        chk("l4_c1", 6'b110100, 2'd0);
        tick(); chk("l4_c2", 6'b100100, 2'd0);
        tick(); chk("l4_c3", 6'b100100, 2'd0);
        tick(); chk("l4_c4", 6'b101100, 2'd0);
        tick(); chk("l4_c5", 6'b000110, 2'd0);
        tick(); chk("l4_c6", 6'b000000, 2'd0);

        // length 1: first and last together
        cfg_len = 8'd1; pulse = 1'b1;
        tick(); pulse = 1'b0;
        chk("l1_c1", 6'b111100, 2'd0);
        tick(); chk("l1_c2", 6'b000110, 2'd0);
        tick(); chk("l1_c3", 6'b000000, 2'd0);

        // length 0 pulse is ignored
        cfg_len = 8'd0; pulse = 1'b1;
        tick(); pulse = 1'b0;
        chk("l0_c1", 6'b000000, 2'd0);
        tick(); chk("l0_c2", 6'b000000, 2'd0);

        // reset at burst cycle 2 with one extra pulse
        cfg_len = 8'd6; pulse = 1'b1;
        tick(); chk("rst_c1", 6'b110100, 2'd0);
        tick(); pulse = 1'b0;
`ifdef PULSE_BURST_QUEUE_EN
        chk("rst_c2", 6'b100100, 2'd1);
`else
        chk("rst_c2", 6'b100101, 2'd0);
`endif
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rst_c3", 6'b000000, 2'd0);
        for (int i = 0; i < 8; i++) begin
            tick(); chk($sformatf("rst_quiet%0d", i), 6'b000000, 2'd0);
        end

`ifdef PULSE_BURST_QUEUE_EN
        // length 3 with two queued pulses: three bursts
        cfg_len = 8'd3; pulse = 1'b1;
        tick(); chk("q3_c1", 6'b110100, 2'd0);
        tick(); chk("q3_c2", 6'b100100, 2'd1);
        tick(); pulse = 1'b0;
        chk("q3_c3", 6'b101100, 2'd2);
        tick(); chk("q3_c4", 6'b000110, 2'd2);
        tick(); chk("q3_c5", 6'b110100, 2'd1);
        tick(); chk("q3_c6", 6'b100100, 2'd1);
        tick(); chk("q3_c7", 6'b101100, 2'd1);
        tick(); chk("q3_c8", 6'b000110, 2'd1);
        tick(); chk("q3_c9", 6'b110100, 2'd0);
        tick(); chk("q3_c10", 6'b100100, 2'd0);
        tick(); chk("q3_c11", 6'b101100, 2'd0);
        tick(); chk("q3_c12", 6'b000110, 2'd0);
        tick(); chk("q3_c13", 6'b000000, 2'd0);

        // saturation, drop, set-wins-over-clear, clear, then reset flushes queue
        cfg_len = 8'd8; pulse = 1'b1;
        tick(); chk("sat_c1", 6'b110100, 2'd0);
        tick(); chk("sat_c2", 6'b100100, 2'd1);
        tick(); chk("sat_c3", 6'b100100, 2'd2);
        tick(); chk("sat_c4", 6'b100100, 2'd3);
        tick(); chk("sat_c5", 6'b100101, 2'd3);
        tick(); chk("sat_c6", 6'b100101, 2'd3);
        drop_clr = 1'b1;
        tick(); pulse = 1'b0;
        chk("sat_c7", 6'b100101, 2'd3);
        tick(); drop_clr = 1'b0;
        chk("sat_c8", 6'b101100, 2'd3);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("sat_rst", 6'b000000, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk($sformatf("sat_quiet%0d", i), 6'b000000, 2'd0);
        end

        // pulse in DONE with empty queue starts the next burst directly
        cfg_len = 8'd2; pulse = 1'b1;
        tick(); pulse = 1'b0;
        chk("dp_c1", 6'b110100, 2'd0);
        tick(); chk("dp_c2", 6'b101100, 2'd0);
        tick(); chk("dp_c3", 6'b000110, 2'd0);
        pulse = 1'b1;
        tick(); pulse = 1'b0;
        chk("dp_c4", 6'b110100, 2'd0);
        tick(); chk("dp_c5", 6'b101100, 2'd0);
        tick(); chk("dp_c6", 6'b000110, 2'd0);
        tick(); chk("dp_c7", 6'b000000, 2'd0);

        // zero length in DONE flushes the queue without a drop
        cfg_len = 8'd2; pulse = 1'b1;
        tick(); chk("fl_c1", 6'b110100, 2'd0);
        tick(); pulse = 1'b0; cfg_len = 8'd0;
        chk("fl_c2", 6'b101100, 2'd1);
        tick(); chk("fl_c3", 6'b000110, 2'd1);
        tick(); chk("fl_c4", 6'b000000, 2'd0);
`else
        // no queue: pulses in BURST and DONE are drops
        cfg_len = 8'd3; pulse = 1'b1;
        tick(); chk("nq_c1", 6'b110100, 2'd0);
        tick(); pulse = 1'b0;
        chk("nq_c2", 6'b100101, 2'd0);
        tick(); chk("nq_c3", 6'b101101, 2'd0);
        tick(); chk("nq_c4", 6'b000111, 2'd0);
        pulse = 1'b1; drop_clr = 1'b1;
        tick(); pulse = 1'b0;
        chk("nq_c5", 6'b000001, 2'd0);
        tick(); drop_clr = 1'b0;
        chk("nq_c6", 6'b000000, 2'd0);
        tick(); chk("nq_c7", 6'b000000, 2'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
